// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch stage and its fetch queue.
package fetch_pkg;

   localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
   localparam int          FETCH_XLEN = 64;
   localparam int          FETCH_ILEN = 32;

   typedef struct packed {
      logic [FETCH_XLEN-1:0] pc;
      logic [FETCH_ILEN-1:0] instr;
      logic                  misaligned;
   } fq_entry_t;

   function automatic int fetch_clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << result) < value) result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/fetch_stage_q_if.sv
// Bundle of the fetch stage's memory, redirect and decode-handshake signals.
interface fetch_stage_q_if #(
   parameter int XLEN = 64,
   parameter int ILEN = 32,
   parameter int CW   = 3
);

   logic            PCSrc_E;
   logic [XLEN-1:0] PC_Target_E;
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic [ILEN-1:0] imem_rdata;
   logic            valid_D;
   logic            ready_D;
   logic [XLEN-1:0] PC_D;
   logic [ILEN-1:0] instruction_D;
   logic            misaligned_D;
   logic [CW-1:0]   fq_count;

   // The fetch stage itself is the master; memory, EX and ID form the slave side.
   modport master (
      input  PCSrc_E, PC_Target_E, imem_rdata, ready_D,
      output imem_req, imem_addr, valid_D, PC_D, instruction_D, misaligned_D, fq_count
   );

   modport slave (
      output PCSrc_E, PC_Target_E, imem_rdata, ready_D,
      input  imem_req, imem_addr, valid_D, PC_D, instruction_D, misaligned_D, fq_count
   );

endinterface

// File: rtl/fetch_fifo.sv
// Fetch queue: power-of-two circular buffer with flush, occupancy count and a
// head output that depends only on stored state.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = logic [7:0]
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic                         push,
   input  entry_t                       push_data,
   input  logic                         pop,
   output entry_t                       head,
   output logic [fetch_clog2(DEPTH):0]  count,
   output logic                         full,
   output logic                         empty
);

   localparam int PW = fetch_clog2(DEPTH);
   localparam int CW = PW + 1;

   entry_t          mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Flush collapses the queue by snapping the read pointer onto the write pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= wr_ptr;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

   assign head = empty ? entry_t'('0) : mem[rd_ptr];

endmodule

// File: rtl/fetch_stage_q.sv
// Instruction-fetch stage: owns the PC, issues credit-limited requests to a
// 1-cycle instruction memory and queues {PC, instruction} pairs for decode.
module fetch_stage_q
   import fetch_pkg::*;
#(
   parameter int              XLEN     = 64,
   parameter int              ILEN     = 32,
   parameter int              FQ_DEPTH = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   fetch_stage_q_if.master fif
);

   localparam int CW = fetch_clog2(FQ_DEPTH) + 1;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
      logic            misaligned;
   } entry_t;

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] req_pc;
   logic            inflight;
   logic            issue;
   logic            pop;
   logic [CW:0]     credit_used;
   logic [CW-1:0]   count;
   logic            full;
   logic            empty;
   entry_t          push_entry;
   entry_t          head;

   // A request is only issued when its response is guaranteed a free slot.
   assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight};
   assign issue       = reset && !fif.PCSrc_E && !full && (credit_used < (CW+1)'(FQ_DEPTH));
   assign pop         = !empty && fif.ready_D;

   assign push_entry.pc         = req_pc;
   assign push_entry.instr      = fif.imem_rdata;
   assign push_entry.misaligned = (req_pc[1:0] != 2'b00);

   // Redirect wins over issue and also drops any response still in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc       <= RESET_PC;
         req_pc   <= '0;
         inflight <= 1'b0;
      end else if (fif.PCSrc_E) begin
         pc       <= fif.PC_Target_E;
         inflight <= 1'b0;
      end else if (issue) begin
         pc       <= pc + XLEN'(4);
         req_pc   <= pc;
         inflight <= 1'b1;
      end else begin
         inflight <= 1'b0;
      end
   end

   fetch_fifo #(
      .DEPTH   (FQ_DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (reset),
      .flush     (fif.PCSrc_E),
      .push      (inflight),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   assign fif.imem_req      = issue;
   assign fif.imem_addr     = pc;
   assign fif.valid_D       = !empty;
   assign fif.PC_D          = head.pc;
   assign fif.instruction_D = head.instr;
   assign fif.misaligned_D  = head.misaligned;
   assign fif.fq_count      = count;

endmodule

// File: tb/tb_fetch_stage_q.sv
// Directed and randomized bench for fetch_stage_q against a queue-level
// reference model of the fetch stage and an address-hashed instruction memory.
module tb_fetch_stage_q;
   import fetch_pkg::*;

   localparam int XLEN  = 64;
   localparam int ILEN  = 32;
   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   fetch_stage_q_if #(.XLEN(XLEN), .ILEN(ILEN), .CW(CW)) fif ();

   fetch_stage_q #(
      .XLEN     (XLEN),
      .ILEN     (ILEN),
      .FQ_DEPTH (DEPTH),
      .RESET_PC (64'h0)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .fif   (fif)
   );

   int compared   = 0;
   int mismatched = 0;

   fq_entry_t       mq  [$];
   fq_entry_t       got [$];
   logic [63:0]     m_pc;
   logic [63:0]     m_req_pc;
   bit              m_inflight;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return NOP_INSTR ^ (a[31:0] << 7) ^ a[63:32] ^ {a[7:0], 24'h0};
   endfunction

   // Instruction memory with one cycle of read latency.
   always @(posedge clk) fif.imem_rdata <= mem_word(fif.imem_addr);

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      fq_entry_t h;
      bit        ev;
      bit        er;
      h  = '0;
      ev = (mq.size() != 0);
      if (ev) h = mq[0];
      er = !fif.PCSrc_E && ((mq.size() + int'(m_inflight)) < DEPTH);
      check("valid_D",       64'(fif.valid_D),       64'(ev));
      check("PC_D",          fif.PC_D,               h.pc);
      check("instruction_D", 64'(fif.instruction_D), 64'(h.instr));
      check("misaligned_D",  64'(fif.misaligned_D),  64'(h.misaligned));
      check("fq_count",      64'(fif.fq_count),      64'(mq.size()));
      check("imem_req",      64'(fif.imem_req),      64'(er));
      check("imem_addr",     fif.imem_addr,          m_pc);
   endtask

   task automatic modelReset();
      mq.delete();
      m_pc       = 64'h0;
      m_req_pc   = 64'h0;
      m_inflight = 1'b0;
   endtask

   // One clock cycle: drive inputs after the falling edge, compare, then advance the model.
   task automatic applyStimulus(input bit rdy, input bit redir, input logic [63:0] tgt);
      bit req;
      bit pop_now;
      fq_entry_t e;
      fif.ready_D     = rdy;
      fif.PCSrc_E     = redir;
      fif.PC_Target_E = tgt;
      #1;
      checkOutput();
      req     = !redir && ((mq.size() + int'(m_inflight)) < DEPTH);
      pop_now = (mq.size() != 0) && rdy && !redir;
      if (fif.valid_D && rdy && !redir) begin
         e.pc         = fif.PC_D;
         e.instr      = fif.instruction_D;
         e.misaligned = fif.misaligned_D;
         got.push_back(e);
      end
      @(posedge clk);
      if (redir) begin
         mq.delete();
         m_inflight = 1'b0;
         m_pc       = tgt;
      end else begin
         if (pop_now) void'(mq.pop_front());
         if (m_inflight) begin
            e.pc         = m_req_pc;
            e.instr      = mem_word(m_req_pc);
            e.misaligned = (m_req_pc[1:0] != 2'b00);
            mq.push_back(e);
         end
         if (req) begin
            m_req_pc   = m_pc;
            m_pc       = m_pc + 64'd4;
            m_inflight = 1'b1;
         end else begin
            m_inflight = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   task automatic runCycles(input int n, input bit rdy);
      for (int i = 0; i < n; i++) applyStimulus(rdy, 1'b0, 64'h0);
   endtask

   task automatic checkStream(input string tag);
      for (int i = 1; i < got.size(); i++) begin
         check({tag, "_contig"}, got[i].pc, got[i-1].pc + 64'd4);
         check({tag, "_instr"}, 64'(got[i].instr), 64'(mem_word(got[i].pc)));
      end
   endtask

   initial begin
      bit reached;
      logic [63:0] tgt;

      reset           = 1'b0;
      fif.ready_D     = 1'b0;
      fif.PCSrc_E     = 1'b0;
      fif.PC_Target_E = 64'h0;
      modelReset();
      repeat (2) @(negedge clk);
      check("rst_valid_D",   64'(fif.valid_D),  64'd0);
      check("rst_fq_count",  64'(fif.fq_count), 64'd0);
      check("rst_imem_req",  64'(fif.imem_req), 64'd0);
      check("rst_imem_addr", fif.imem_addr,     64'h0);
      check("rst_PC_D",      fif.PC_D,          64'h0);
      reset = 1'b1;

      // Fill from empty and stream with decode always ready.
      got.delete();
      runCycles(6, 1'b1);
      check("t1_count", 64'(got.size()), 64'd4);
      if (got.size() >= 4) begin
         for (int i = 0; i < 4; i++) check("t1_pc", got[i].pc, 64'(4 * i));
      end

      // Back-pressure: queue saturates, requests stop, nothing lost on resume.
      got.delete();
      runCycles(10, 1'b0);
      check("t2_full",     64'(fif.fq_count), 64'd4);
      check("t2_req_stop", 64'(fif.imem_req), 64'd0);
      runCycles(8, 1'b1);
      check("t2_delivered", 64'(got.size() >= 5), 64'd1);
      checkStream("t2");

      // Redirect while three entries are queued and one response is in flight.
      reached = 1'b0;
      for (int i = 0; i < 12 && !reached; i++) begin
         if (mq.size() == 3 && m_inflight) reached = 1'b1;
         else applyStimulus(1'b0, 1'b0, 64'h0);
      end
      check("t3_setup", 64'(reached), 64'd1);
      applyStimulus(1'b0, 1'b1, 64'h100);
      check("t3_valid_after", 64'(fif.valid_D),  64'd0);
      check("t3_count_after", 64'(fif.fq_count), 64'd0);
      got.delete();
      runCycles(8, 1'b1);
      check("t3_first_pc", (got.size() > 0) ? got[0].pc : 64'hDEAD, 64'h100);
      checkStream("t3");

      // Fill to full, then drain with decode ready every cycle.
      reached = 1'b0;
      for (int i = 0; i < 12 && !reached; i++) begin
         if (mq.size() == DEPTH) reached = 1'b1;
         else applyStimulus(1'b0, 1'b0, 64'h0);
      end
      check("t4_full_reached", 64'(reached), 64'd1);
      got.delete();
      runCycles(12, 1'b1);
      checkStream("t4");

      // Misaligned redirect target is fetched as-is and flagged.
      got.delete();
      applyStimulus(1'b1, 1'b1, 64'h102);
      runCycles(8, 1'b1);
      check("t5_pc0",  (got.size() > 1) ? got[0].pc : 64'hDEAD, 64'h102);
      check("t5_mis0", (got.size() > 1) ? 64'(got[0].misaligned) : 64'd9, 64'd1);
      check("t5_pc1",  (got.size() > 1) ? got[1].pc : 64'hDEAD, 64'h106);
      check("t5_mis1", (got.size() > 1) ? 64'(got[1].misaligned) : 64'd9, 64'd1);

      // PC wraps modulo 2^64.
      got.delete();
      applyStimulus(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
      runCycles(8, 1'b1);
      check("wrap_pc0", (got.size() > 2) ? got[0].pc : 64'hDEAD, 64'hFFFF_FFFF_FFFF_FFF8);
      check("wrap_pc1", (got.size() > 2) ? got[1].pc : 64'hDEAD, 64'hFFFF_FFFF_FFFF_FFFC);
      check("wrap_pc2", (got.size() > 2) ? got[2].pc : 64'hDEAD, 64'h0);

      // Random back-pressure and redirects, including misaligned targets.
      for (int i = 0; i < 300; i++) begin
         tgt = {$urandom(), $urandom()};
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, tgt);
      end

      // Asynchronous reset pulsed between clock edges while streaming.
      runCycles(4, 1'b1);
      #2 reset = 1'b0;
      #1;
      check("arst_valid_D",   64'(fif.valid_D),  64'd0);
      check("arst_fq_count",  64'(fif.fq_count), 64'd0);
      check("arst_imem_req",  64'(fif.imem_req), 64'd0);
      check("arst_imem_addr", fif.imem_addr,     64'h0);
      check("arst_PC_D",      fif.PC_D,          64'h0);
      modelReset();
      @(posedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      got.delete();
      runCycles(8, 1'b1);
      check("arst_restart0", (got.size() > 1) ? got[0].pc : 64'hDEAD, 64'h0);
      check("arst_restart1", (got.size() > 1) ? got[1].pc : 64'hDEAD, 64'h4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
